// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receiver / register block side (master) and the
// receive FIFO (slave). Clock and reset are carried as plain module ports.
interface uart_rx_fifo_if #(
    parameter int AW = 4
);
    // Receiver side and register-block requests
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        rx_err;
    logic        rd_en;
    logic        clr_status;

    // FIFO status and head-of-queue data
    logic [7:0]  rd_data;
    logic        empty;
    logic        full;
    logic [AW:0] count;
    logic        overrun;
    logic        frame_err;
    logic        irq;

    modport master (
        output rx_data, rx_done, rx_err, rd_en, clr_status,
        input  rd_data, empty, full, count, overrun, frame_err, irq
    );

    modport slave (
        input  rx_data, rx_done, rx_err, rd_en, clr_status,
        output rd_data, empty, full, count, overrun, frame_err, irq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the 8-bit UART receiver. Each rising
// edge of the receiver's done strobe pushes one byte into a first-word-
// fall-through FIFO; the register block pops with rd_en. Overrun and
// framing-error conditions are kept as sticky flags, and irq is a level
// indication that the fill level has reached THRESH.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int THRESH = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);

    localparam logic [AW:0]   FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   IRQ_LVL   = (AW+1)'(THRESH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(0);

    // Storage (not cleared by reset; only pointers/count define validity)
    logic [7:0]    mem_q [DEPTH];

    // Pointer, occupancy and edge-detector state
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;

    // Decoded per-cycle events
    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic          accept_s;
    logic          drop_s;
    logic          err_rise_s;

    assign empty_s    = (count_q == CNT_ZERO);
    assign full_s     = (count_q == FULL_LVL);

    // A held done produces one push: only its rising edge counts.
    assign push_s     = bus.rx_done & ~done_q;
    assign err_rise_s = bus.rx_err & ~err_q;

    // A pop on an empty FIFO is ignored entirely.
    assign pop_s      = bus.rd_en & ~empty_s;

    // When full, a push still fits if the same cycle frees a slot.
    assign accept_s   = push_s & (~full_s | pop_s);
    assign drop_s     = push_s & full_s & ~pop_s;

    // Next-state for pointers, occupancy, edge detectors and sticky flags
    always_comb begin
        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        done_d      = bus.rx_done;
        err_d       = bus.rx_err;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;

        if (accept_s) begin
            wp_d = wp_q + PTR_ONE;
        end else begin
            wp_d = wp_q;
        end

        if (pop_s) begin
            rp_d = rp_q + PTR_ONE;
        end else begin
            rp_d = rp_q;
        end

        case ({accept_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A set event in the same cycle as clr_status wins.
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (bus.clr_status) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        if (err_rise_s) begin
            frame_err_d = 1'b1;
        end else if (bus.clr_status) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end
    end

    // Control state registers with synchronous reset that overrides all events
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q        <= PTR_ZERO;
            rp_q        <= PTR_ZERO;
            count_q     <= CNT_ZERO;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            done_q      <= done_d;
            err_q       <= err_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Byte storage write; a push coinciding with reset is discarded
    always_ff @(posedge clk) begin
        if (!rst && accept_s) begin
            mem_q[wp_q] <= bus.rx_data;
        end
    end

    // Status outputs all derive from registered state
    assign bus.rd_data   = mem_q[rp_q];
    assign bus.empty     = empty_s;
    assign bus.full      = full_s;
    assign bus.count     = count_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
    assign bus.irq       = (count_q >= IRQ_LVL);

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

- Receive-side byte buffer sitting directly downstream of the 8-bit UART receiver.
- Captures each completed byte on the receiver's `done` pulse and holds it in a first-word-fall-through FIFO until the APB/UART register block reads it.
- Tracks overrun and framing-error status as sticky flags.
- Drives a level interrupt when the fill level reaches a programmable threshold.

## Interface

Parameters:
- `DEPTH`, default 16: number of entries; must be a power of two, at least 2.
- `AW`, default 4: pointer width; must equal log2(DEPTH).
- `THRESH`, default 8: interrupt threshold, in the range 1..DEPTH.

Ports:
- `clk` in 1: single clock for all logic; the receiver's outputs are in this domain.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: receiver `out`.
- `rx_done` in 1: receiver `done`.
- `rx_err` in 1: receiver `err`.
- `rd_en` in 1: pop request from the register block.
- `clr_status` in 1: clears the sticky flags.
- `rd_data` out 8: head entry.
- `empty` out 1: FIFO holds no entries.
- `full` out 1: FIFO holds DEPTH entries.
- `count` out AW+1: current number of entries.
- `overrun` out 1: sticky; a byte was dropped.
- `frame_err` out 1: sticky; the receiver flagged an error.
- `irq` out 1: `count >= THRESH`.

## Operation

- Storage is a DEPTH x 8 register array with write pointer `wp` and read pointer `rp`, each AW bits wide and wrapping naturally from DEPTH-1 to 0.
- `count` is a separate AW+1-bit register.
- Push event: a rising edge of `rx_done`, i.e. `rx_done` high while `done_q` (`rx_done` delayed one cycle) is low.
  - A `done` held high for several cycles yields exactly one push.
- Pop event: `rd_en && !empty`. `rd_en` while empty is ignored; no state changes.
- Push accepted when `!full`, or when full and a pop occurs in the same cycle.
  - Accepted: `mem[wp] <= rx_data`, `wp <= wp+1`.
- Push while full with no pop: the byte is dropped; `wp`, `mem` and `count` are unchanged; `overrun <= 1`.
- Pop: `rp <= rp+1`.
- Count update per cycle: +1 for push only, -1 for pop only, unchanged for both or neither.
- Push and pop together while empty: the pop is ignored (empty) and the push is accepted, so `count` becomes 1.
- `frame_err <= 1` on a rising edge of `rx_err`, detected with `err_q`.
- `clr_status` clears `overrun` and `frame_err`.
  - If a set event occurs in the same cycle as `clr_status`, the set wins and the flag reads 1 next cycle.
- Combinational outputs:
  - `rd_data = mem[rp]`.
  - `empty = (count == 0)`.
  - `full = (count == DEPTH)`.
  - `irq = (count >= THRESH)`.
- `rd_data` is don't-care while `empty`; the bench must not check it then.
- Reset (synchronous, wins over everything):
  - `wp`, `rp`, `count`, `done_q`, `err_q`, `overrun`, `frame_err` all go to 0.
  - Memory contents are not cleared.
  - Reset outputs: `empty=1`, `full=0`, `count=0`, `irq=0`, `overrun=0`, `frame_err=0`.
  - Any push or pop in the reset cycle is discarded.
- No FSM beyond the pointer/count registers and the two edge detectors.

## Timing

- Push latency: with a `rx_done` rising edge at cycle N, the byte is stored at the N+1 edge; `empty` falls and `count` increments visibly in cycle N+1.
  - If the FIFO was empty, `rd_data` shows that byte in cycle N+1 (FWFT).
- Pop: with `rd_en` sampled high at edge N, `rd_data` shows the next entry after that edge; there are no read wait states.
- Back-to-back pops on consecutive cycles are supported at one byte per cycle.
- Back-to-back pushes require `rx_done` to fall between bytes; the receiver guarantees this.
- Flags (`full`, `empty`, `irq`) are derived from the registered `count`, so they are glitch-free relative to `clk`.
- `overrun` and `frame_err` assert in the cycle after the triggering edge.
  - Clearing via `clr_status` at edge N takes effect in cycle N+1.

## Test plan

- Reset then single byte: pulse `rx_done` for one cycle with `rx_data`=0xA5.
  - Next cycle: `empty`=0, `count`=1, `rd_data`=0xA5.
  - After `rd_en` for one cycle: `empty`=1, `count`=0.
- Fill and order, DEPTH=16: push 0x00..0x0F.
  - `irq` rises when `count` reaches 8; `full`=1 at 16.
  - Pop all 16 on consecutive cycles: `rd_data` sequence 0x00..0x0F, then `empty`=1 and `irq`=0.
- Overrun: on a full FIFO, push 0xEE with no pop.
  - `overrun`=1, `count` stays 16, and 0xEE never appears on `rd_data`.
  - `clr_status` then gives `overrun`=0.
- Simultaneous push/pop:
  - On a full FIFO, push 0x77 together with `rd_en`: `count` stays 16, the oldest byte is removed, and 0x77 emerges last.
  - On an empty FIFO, push 0x33 together with `rd_en`: `count`=1, `rd_data`=0x33.
- Held `done` and error: hold `rx_done` high for 5 cycles, which gives exactly one push. Pulse `rx_err` while asserting `clr_status` in the same cycle; `frame_err` must read 1.
- Wrap and mid-operation reset:
  - Push/pop 40 bytes with random interleaving (count 0..16); read order must match a reference queue.
  - Assert `rst` with `count`=5 and a simultaneous push: next cycle `count`=0, `empty`=1, all flags 0.
